// File: rtl/tensor_rd_arbiter.sv
// rtl/tensor_rd_arbiter.sv - round-robin arbiter sharing one tensor read engine between load requesters
//
// Purpose: grants one burst request at a time to the axi_tensor_rd engine, then steers
// the returned beats to the owning requester and checks beat order and count.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   req_valid/req_ready      per-requester request handshake (req_ready is one-hot)
//   req_base/burst_num/size  packed per-requester request fields, slice i = requester i
//   rsp_data                 registered beat, broadcast to all requesters
//   rsp_valid/last/done      one-hot beat valid, last beat, burst-complete pulse
//   axi_out_*                latched request towards the engine, sel = owning requester
//   axi_in_*                 engine accept strobe and returned beat stream
//   busy, err                not idle; sticky protocol error

module tensor_rd_arbiter #(
    parameter int NREQ       = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*ADDR_WIDTH-1:0]   req_base,
    input  logic [NREQ*6-1:0]            req_burst_num,
    input  logic [NREQ*3-1:0]            req_burst_size,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [NREQ-1:0]              rsp_last,
    output logic [NREQ-1:0]              rsp_done,
    output logic                         axi_out_request_valid,
    output logic [ADDR_WIDTH-1:0]        axi_out_BASE,
    output logic [5:0]                   axi_out_burst_num,
    output logic [2:0]                   axi_out_burst_size,
    output logic [2:0]                   axi_out_sel,
    input  logic                         axi_in_arready,
    input  logic [DATA_WIDTH-1:0]        axi_in_data,
    input  logic                         axi_in_valid,
    input  logic                         axi_in_finish,
    input  logic [31:0]                  axi_in_burst_id,
    output logic                         busy,
    output logic                         err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              ptr;
    // One bit wider than burst_num so an over-long burst cannot wrap back into range.
    logic [6:0]              bcnt;
    logic [NREQ-1:0]         rot;
    logic [2:0]              off;
    logic [3:0]              grant_sum;
    logic [2:0]              grant;
    logic                    grant_vld;
    logic                    handshake;
    logic [ADDR_WIDTH-1:0]   g_base;
    logic [5:0]              g_num;
    logic [2:0]              g_size;
    logic [NREQ-1:0]         sel_oh;
    logic                    id_bad;
    logic                    beat_over;
    logic                    count_bad;
    logic                    unused_id_bits;

    // Rotate the request vector so bit 0 is the requester at ptr; the lowest set
    // bit of the rotated vector is then the round-robin winner's offset from ptr.
    assign rot = NREQ'({req_valid, req_valid} >> ptr);

    always_comb begin
        off       = 3'd0;
        grant_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off       = 3'(k);
                grant_vld = 1'b1;
            end
        end
        grant_sum = {1'b0, ptr} + {1'b0, off};
        grant     = (grant_sum >= 4'(NREQ)) ? 3'(grant_sum - 4'(NREQ)) : grant_sum[2:0];
    end

    // req_ready is combinational, so it is gated by reset to stay 0 while held in reset.
    always_comb begin
        req_ready = '0;
        g_base    = '0;
        g_num     = '0;
        g_size    = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant == 3'(j)) begin
                g_base = req_base[j*ADDR_WIDTH +: ADDR_WIDTH];
                g_num  = req_burst_num[j*6 +: 6];
                g_size = req_burst_size[j*3 +: 3];
                if (aresetn && (state == S_IDLE) && grant_vld) begin
                    req_ready[j] = 1'b1;
                end
            end
        end
    end

    assign handshake = |(req_valid & req_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (handshake) state_nxt = S_ISSUE;
            S_ISSUE:  if (axi_in_arready) state_nxt = S_STREAM;
            S_STREAM: if (axi_in_valid && axi_in_finish) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign axi_out_request_valid = (state == S_ISSUE);
    assign busy                  = (state != S_IDLE);

    assign sel_oh         = {{(NREQ-1){1'b0}}, 1'b1} << axi_out_sel;
    assign id_bad         = (axi_in_burst_id[5:0] != bcnt[5:0]);
    assign beat_over      = (bcnt > {1'b0, axi_out_burst_num});
    assign count_bad      = (bcnt != {1'b0, axi_out_burst_num});
    assign unused_id_bits = ^axi_in_burst_id[31:6];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr                <= 3'd0;
            bcnt               <= 7'd0;
            axi_out_BASE       <= '0;
            axi_out_burst_num  <= 6'd0;
            axi_out_burst_size <= 3'd0;
            axi_out_sel        <= 3'd0;
            rsp_data           <= '0;
            rsp_valid          <= '0;
            rsp_last           <= '0;
            rsp_done           <= '0;
            err                <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_last  <= '0;
            rsp_done  <= '0;

            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        axi_out_BASE       <= g_base;
                        axi_out_burst_num  <= g_num;
                        axi_out_burst_size <= g_size;
                        axi_out_sel        <= grant;
                        bcnt               <= 7'd0;
                    end
                end
                S_STREAM: begin
                    if (axi_in_valid) begin
                        rsp_data  <= axi_in_data;
                        rsp_valid <= sel_oh;
                        bcnt      <= bcnt + 7'd1;
                        if (id_bad || beat_over) begin
                            err <= 1'b1;
                        end
                        // rsp_done is registered here so it lands with the last beat.
                        if (axi_in_finish) begin
                            rsp_last <= sel_oh;
                            rsp_done <= sel_oh;
                            if (count_bad) begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    ptr <= (axi_out_sel == 3'(NREQ - 1)) ? 3'd0 : axi_out_sel + 3'd1;
                end
                default: begin
                end
            endcase

            // Beats outside STREAM are dropped; accepts outside ISSUE are ignored.
            if (axi_in_valid && ((state == S_IDLE) || (state == S_ISSUE))) begin
                err <= 1'b1;
            end
            if (axi_in_arready && (state != S_ISSUE)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tensor_rd_arbiter.sv
// tb/tb_tensor_rd_arbiter.sv - scoreboard bench for tensor_rd_arbiter

module tb_tensor_rd_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 256;

    logic                 aclk;
    logic                 aresetn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_base;
    logic [NREQ*6-1:0]    req_burst_num;
    logic [NREQ*3-1:0]    req_burst_size;
    logic [DW-1:0]        rsp_data;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_last;
    logic [NREQ-1:0]      rsp_done;
    logic                 axi_out_request_valid;
    logic [AW-1:0]        axi_out_BASE;
    logic [5:0]           axi_out_burst_num;
    logic [2:0]           axi_out_burst_size;
    logic [2:0]           axi_out_sel;
    logic                 axi_in_arready;
    logic [DW-1:0]        axi_in_data;
    logic                 axi_in_valid;
    logic                 axi_in_finish;
    logic [31:0]          axi_in_burst_id;
    logic                 busy;
    logic                 err;

    tensor_rd_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk                  (aclk),
        .aresetn               (aresetn),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_base              (req_base),
        .req_burst_num         (req_burst_num),
        .req_burst_size        (req_burst_size),
        .rsp_data              (rsp_data),
        .rsp_valid             (rsp_valid),
        .rsp_last              (rsp_last),
        .rsp_done              (rsp_done),
        .axi_out_request_valid (axi_out_request_valid),
        .axi_out_BASE          (axi_out_BASE),
        .axi_out_burst_num     (axi_out_burst_num),
        .axi_out_burst_size    (axi_out_burst_size),
        .axi_out_sel           (axi_out_sel),
        .axi_in_arready        (axi_in_arready),
        .axi_in_data           (axi_in_data),
        .axi_in_valid          (axi_in_valid),
        .axi_in_finish         (axi_in_finish),
        .axi_in_burst_id       (axi_in_burst_id),
        .busy                  (busy),
        .err                   (err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int            sel;
        logic [DW-1:0] data;
        bit            last;
    } beat_t;

    int        checks = 0;
    int        errors = 0;
    beat_t     sbq[$];
    beat_t     mon_e;
    bit        mon_en = 0;
    int        model_ptr = 0;
    logic [AW-1:0] exp_base [NREQ];
    logic [5:0]    exp_num  [NREQ];
    logic [2:0]    exp_size [NREQ];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first requesting index scanning upward from ptr, modulo NREQ.
    function automatic int pick(input int p, input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Monitor: every presented beat must match the oldest expected beat.
    always @(negedge aclk) begin
        if (mon_en) begin
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=%0h expected none", rsp_valid);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rsp_valid", rsp_valid, 3'b001 << mon_e.sel);
                    chk("rsp_data", rsp_data, mon_e.data);
                    chk("rsp_last", rsp_last, mon_e.last ? (3'b001 << mon_e.sel) : 3'b000);
                    chk("rsp_done", rsp_done, mon_e.last ? (3'b001 << mon_e.sel) : 3'b000);
                end
            end else if (rsp_last != '0 || rsp_done != '0) begin
                checks++;
                errors++;
                $display("FAIL stray_last_done: last=%0h done=%0h expected 0", rsp_last, rsp_done);
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] b, input logic [5:0] n, input logic [2:0] s);
        req_base[i*AW +: AW]     = b;
        req_burst_num[i*6 +: 6]  = n;
        req_burst_size[i*3 +: 3] = s;
        exp_base[i] = b;
        exp_num[i]  = n;
        exp_size[i] = s;
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_last"}, rsp_last, 0);
        chk({tag, "_rsp_done"}, rsp_done, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_out_valid"}, axi_out_request_valid, 0);
        chk({tag, "_out_base"}, axi_out_BASE, 0);
        chk({tag, "_out_num"}, axi_out_burst_num, 0);
        chk({tag, "_out_size"}, axi_out_burst_size, 0);
        chk({tag, "_out_sel"}, axi_out_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic do_reset();
        mon_en  = 0;
        aresetn = 1'b0;
        tick();
        aresetn   = 1'b1;
        model_ptr = 0;
        sbq.delete();
        mon_en = 1;
    endtask

    task automatic drive_beat(input int id, input bit fin, input bit push, input int w);
        logic [DW-1:0] d;
        beat_t e;
        for (int q = 0; q < 8; q++) d[q*32 +: 32] = $urandom();
        axi_in_valid    = 1'b1;
        axi_in_data     = d;
        axi_in_burst_id = id;
        axi_in_finish   = fin;
        if (push) begin
            e.sel  = w;
            e.data = d;
            e.last = fin;
            sbq.push_back(e);
        end
    endtask

    // mode 0: in-order beats; mode 1: ids 0,2,3..; mode 2: finish on beat 1.
    task automatic run_burst(input logic [NREQ-1:0] mask, input bit hold, input int arr_delay,
                             input bit gaps, input int mode);
        int w;
        int n;
        w = pick(model_ptr, mask);
        req_valid = mask;
        #1;
        chk("grant_ready", req_ready, 3'b001 << w);
        tick();
        if (!hold) req_valid = '0;
        chk("issue_valid", axi_out_request_valid, 1);
        chk("issue_sel", axi_out_sel, w);
        chk("issue_base", axi_out_BASE, exp_base[w]);
        chk("issue_num", axi_out_burst_num, exp_num[w]);
        chk("issue_size", axi_out_burst_size, exp_size[w]);
        chk("issue_busy", busy, 1);
        for (int c = 0; c < arr_delay; c++) begin
            tick();
            chk("hold_valid", axi_out_request_valid, 1);
            chk("hold_sel", axi_out_sel, w);
            chk("hold_base", axi_out_BASE, exp_base[w]);
            chk("hold_num", axi_out_burst_num, exp_num[w]);
            chk("hold_size", axi_out_burst_size, exp_size[w]);
            chk("hold_no_grant", req_ready, 0);
        end
        axi_in_arready = 1'b1;
        tick();
        axi_in_arready = 1'b0;
        chk("valid_drop", axi_out_request_valid, 0);
        n = (mode == 2) ? 2 : int'(exp_num[w]) + 1;
        for (int b = 0; b < n; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            drive_beat((mode == 1 && b > 0) ? b + 1 : b, (b == n - 1), 1, w);
            if (b == n - 1) req_valid = '0;
            tick();
            axi_in_valid  = 1'b0;
            axi_in_finish = 1'b0;
        end
        tick();
        chk("end_idle", busy, 0);
        chk("sb_drain", sbq.size(), 0);
        model_ptr = (w + 1) % NREQ;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        aresetn         = 1'b0;
        req_valid       = '0;
        req_base        = '0;
        req_burst_num   = '0;
        req_burst_size  = '0;
        axi_in_arready  = 1'b0;
        axi_in_data     = '0;
        axi_in_valid    = 1'b0;
        axi_in_finish   = 1'b0;
        axi_in_burst_id = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h0, 6'd0, 3'd0);
        #2;
        req_valid = 3'b111;
        #1;
        rst_check("por");
        req_valid = '0;
        tick();
        tick();
        aresetn = 1'b1;
        mon_en  = 1;

        // Single burst from R1.
        set_req(1, 32'h1000, 6'd3, 3'd5);
        run_burst(3'b010, 0, 2, 0, 0);
        chk("single_err", err, 0);

        // Round-robin with all three requesting, then R1 withdraws.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h100 * (i + 1), 6'd0, 3'd5);
        for (int r = 0; r < 4; r++) run_burst(3'b111, 1, 0, 0, 0);
        for (int r = 0; r < 3; r++) run_burst(3'b101, 1, 0, 0, 0);
        chk("rr_err", err, 0);

        // Out-of-order beat ids.
        do_reset();
        set_req(0, 32'h3000, 6'd1, 3'd5);
        run_burst(3'b001, 0, 0, 0, 1);
        chk("bad_order_err", err, 1);

        // Early finish.
        do_reset();
        chk("err_cleared", err, 0);
        set_req(0, 32'h4000, 6'd3, 3'd5);
        run_burst(3'b001, 0, 1, 0, 2);
        chk("early_finish_err", err, 1);

        // Spurious beat in IDLE.
        do_reset();
        drive_beat(0, 0, 0, 0);
        tick();
        axi_in_valid = 1'b0;
        chk("spurious_rsp", rsp_valid, 0);
        chk("spurious_err", err, 1);
        tick();

        // Accept strobe outside ISSUE.
        do_reset();
        axi_in_arready = 1'b1;
        tick();
        axi_in_arready = 1'b0;
        chk("stray_arready_err", err, 1);
        chk("stray_arready_idle", busy, 0);

        // Reset during beat 2 of a 4-beat burst.
        do_reset();
        set_req(1, 32'h2000, 6'd3, 3'd5);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        axi_in_arready = 1'b1;
        tick();
        axi_in_arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            drive_beat(b, 0, 1, 1);
            tick();
            axi_in_valid = 1'b0;
        end
        drive_beat(2, 0, 0, 1);
        @(negedge aclk);
        #1;
        mon_en = 0;
        chk("mid_sb_drain", sbq.size(), 0);
        aresetn   = 1'b0;
        req_valid = 3'b111;
        #1;
        rst_check("mid");
        req_valid    = '0;
        axi_in_valid = 1'b0;
        tick();
        aresetn   = 1'b1;
        model_ptr = 0;
        tick();
        mon_en = 1;
        set_req(2, 32'h5000, 6'd1, 3'd4);
        run_burst(3'b100, 0, 1, 0, 0);
        chk("post_reset_err", err, 0);

        // Back-pressure with every requester waiting.
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h6000 + 32'h40 * i, 6'(i + 1), 3'd5);
        run_burst(3'b111, 1, 20, 0, 0);
        chk("bp_err", err, 0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, $urandom(), 6'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            run_burst(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1, 0);
        end
        chk("random_err", err, 0);
        chk("final_sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tensor_rd_arbiter.md
# tensor_rd_arbiter

Round-robin arbiter that shares the single `axi_tensor_rd` read engine between up to `NREQ` tensorcore load requesters (A, B, C/accumulator loaders). It accepts one burst request at a time and forwards it to the engine with `axi_out_sel` set to the winner's index. It then steers the returned beats back to the owning requester and checks beat order and count. It sits between the tensorcore load units and `axi_tensor_rd`; only one burst is in flight at any time.

## Interface
Parameters:
- `NREQ`, 3, number of requesters (2..8)
- `ADDR_WIDTH`, 32, base address width
- `DATA_WIDTH`, 256, beat width

Ports:
- `aclk`  in  1  clock
- `aresetn`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester request
- `req_ready`  out  NREQ  one-hot grant; the request is accepted when `req_valid[i]&req_ready[i]`
- `req_base`  in  NREQ*ADDR_WIDTH  packed base addresses; slice i = requester i
- `req_burst_num`  in  NREQ*6  beats-1 per request
- `req_burst_size`  in  NREQ*3  AXI size code per request
- `rsp_data`  out  DATA_WIDTH  returned beat, broadcast to all requesters
- `rsp_valid`  out  NREQ  one-hot beat valid
- `rsp_last`  out  NREQ  last beat of the burst
- `rsp_done`  out  NREQ  burst-complete pulse
- `axi_out_request_valid`  out  1  request to the engine
- `axi_out_BASE`  out  32  latched base address
- `axi_out_burst_num`  out  6  latched beats-1
- `axi_out_burst_size`  out  3  latched size code
- `axi_out_sel`  out  3  grant index
- `axi_in_arready`  in  1  engine accepts the request
- `axi_in_data`  in  DATA_WIDTH  beat data
- `axi_in_valid`  in  1  beat valid
- `axi_in_finish`  in  1  final beat of the burst
- `axi_in_burst_id`  in  32  beat index within the burst, counting from 0
- `busy`  out  1  state != IDLE
- `err`  out  1  sticky protocol error

## Operation
- States: IDLE, ISSUE, STREAM, DONE.
- **IDLE:**
  - `grant` is combinational: the first `req_valid` bit found scanning from `ptr` upward, modulo NREQ.
  - `req_ready[grant]` = 1 in the same cycle; all other bits are 0.
  - On handshake: latch base, num, size and `sel=grant`; clear the beat counter `bcnt`; go to ISSUE.
- **ISSUE:**
  - `axi_out_request_valid`=1 and all `axi_out_*` fields are held stable.
  - On `axi_in_arready`=1: drop valid next cycle and go to STREAM.
- **STREAM:** on each `axi_in_valid`:
  - Register `axi_in_data` into `rsp_data`; set `rsp_valid[sel]` for 1 cycle.
  - If `axi_in_burst_id[5:0] != bcnt`, or `bcnt > burst_num`, set `err`.
  - Increment `bcnt`.
  - If `axi_in_finish`=1 on that beat: set `rsp_last[sel]` with the registered beat; if `bcnt != burst_num`, set `err`; go to DONE.
- **DONE:** `rsp_done[sel]`=1 for 1 cycle; `ptr <= (sel+1) mod NREQ`; go to IDLE.
- Fairness: a requester that holds `req_valid` continuously is granted within NREQ bursts.
- `err` is set by:
  - `axi_in_valid` arriving in IDLE or ISSUE; the beat is dropped and no `rsp_valid` is raised.
  - `axi_in_arready` arriving outside ISSUE; it is ignored.
- `err` clears only on reset.
- Requester fields are sampled only on the handshake cycle. A requester may withdraw `req_valid` before it is granted, with no side effect.

## Timing
- Reset value of every output is 0:
  - `req_ready` is 0 under reset.
  - `ptr`=0, state=IDLE, `bcnt`=0.
- Reset is asynchronous: asserting it mid-burst returns to IDLE immediately and drops `axi_out_request_valid` and all `rsp_*` outputs. Any remaining engine beats after reset release raise `err`.
- Grant to engine request: `req_valid` at cycle 0 in IDLE gives `req_ready` at cycle 0 and `axi_out_request_valid` at cycle 1.
- Beat response latency: `axi_in_valid` at cycle t gives `rsp_valid`/`rsp_data` at t+1. `rsp_last` is coincident with the last `rsp_valid`.
- End of burst:
  - `rsp_done` is asserted at t+1 after the finish beat, i.e. in the same cycle as `rsp_last`.
  - IDLE is re-entered at t+2; the next grant is possible at t+2.
- Minimum burst-to-burst turnaround: 3 cycles of overhead beyond the beats.
- Simultaneous `req_valid` from all requesters: the winner is `ptr`; grants then proceed `ptr+1`, `ptr+2`, and so on.
- `burst_num`=0 is a 1-beat burst: finish arrives on beat 0 with `bcnt`=0, and no error is raised.

## Test plan
- **Single burst:** reset; R1 requests base=0x1000, num=3, size=5; arready after 2 cycles; 4 beats with ids 0..3, finish on id 3.
  - Expect `axi_out_sel`=1 and `axi_out_BASE`=0x1000.
  - Expect 4 `rsp_valid[1]` pulses, `rsp_last[1]`/`rsp_done[1]` on the 4th, `err`=0.
- **Round-robin:** R0, R1 and R2 all hold `req_valid` with num=0.
  - Expect grant order 0,1,2,0.
  - After R1 drops its request, expect order 2,0,2.
- **Bad order:** beat ids 0,2 sent for num=1 → `err`=1 after the 2nd beat; the burst still completes with `rsp_done`.
- **Early/late finish and spurious beats:**
  - Finish on beat 1 with num=3 → `err`=1.
  - `axi_in_valid` in IDLE → `err`=1 and no `rsp_valid`.
- **Reset mid-burst:** assert `aresetn`=0 during STREAM beat 2.
  - Expect all outputs 0 asynchronously.
  - After release, a new R2 request is granted with `ptr`=0 priority.
- **Back-pressure:** hold `axi_in_arready`=0 for 20 cycles → `axi_out_request_valid` and all `axi_out_*` fields stay stable, and no grant is given to other requesters.
